// File: rtl/ika2151_dac_receiver.sv
// YM3012-style DAC front end: deserialises the OPM serial audio stream and
// decodes each floating-point channel word to 16-bit signed linear PCM.
module ika2151_dac_receiver #(
   parameter int ZERO_EXP_MUTE = 1
) (
   input  logic        i_EMUCLK,
   input  logic        i_RST,
   input  logic        i_phi1_NCEN_n,
   input  logic        i_SO,
   input  logic        i_SH1,
   input  logic        i_SH2,
   output logic [15:0] o_L,
   output logic [15:0] o_R,
   output logic        o_L_VALID,
   output logic        o_R_VALID,
   output logic        o_FRAME_ERR,
   output logic        o_LOCKED
);

   typedef enum logic {
      CH_L = 1'b0,
      CH_R = 1'b1
   } ch_t;

   logic [15:0] sr;
   logic [4:0]  bitcnt;
   logic        sh1_d;
   logic        sh2_d;
   ch_t         expect_ch;

   logic        fall1;
   logic        fall2;
   logic        word_ok;
   logic [15:0] sample;

   // Word layout: [15:13] exponent, [12:3] offset-binary mantissa, [2:0] padding.
   function automatic logic [15:0] decode(input logic [15:0] w);
      logic [2:0]  e;
      logic [9:0]  s;
      logic [15:0] ext;
      e   = w[15:13];
      s   = {~w[12], w[11:3]};
      ext = {{6{s[9]}}, s};
      if (e == 3'd0) begin
         if (ZERO_EXP_MUTE != 0) return 16'h0000;
         return ext;
      end
      return ext << (e - 3'd1);
   endfunction

   always_comb begin
      fall1   = sh1_d & ~i_SH1;
      fall2   = sh2_d & ~i_SH2;
      word_ok = (bitcnt == 5'd16) && !(fall1 && fall2);
      sample  = decode(sr);
   end

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         sr          <= '0;
         bitcnt      <= '0;
         sh1_d       <= 1'b0;
         sh2_d       <= 1'b0;
         expect_ch   <= CH_L;
         o_L         <= '0;
         o_R         <= '0;
         o_L_VALID   <= 1'b0;
         o_R_VALID   <= 1'b0;
         o_FRAME_ERR <= 1'b0;
         o_LOCKED    <= 1'b0;
      end else begin
         // NOTE: pulses default low here so each lasts exactly one clock.
         o_L_VALID   <= 1'b0;
         o_R_VALID   <= 1'b0;
         o_FRAME_ERR <= 1'b0;
         if (!i_phi1_NCEN_n) begin
            sr    <= {i_SO, sr[15:1]};
            sh1_d <= i_SH1;
            sh2_d <= i_SH2;
            if (fall1 || fall2) begin
               bitcnt <= 5'd1;
               if (!word_ok) begin
                  o_FRAME_ERR <= 1'b1;
                  o_LOCKED    <= 1'b0;
               end else if (fall1) begin
                  o_L       <= sample;
                  o_L_VALID <= 1'b1;
                  expect_ch <= CH_R;
                  if (expect_ch != CH_L) o_LOCKED <= 1'b0;
               end else begin
                  o_R       <= sample;
                  o_R_VALID <= 1'b1;
                  expect_ch <= CH_L;
                  // An in-order R completes an L/R pair and establishes lock.
                  o_LOCKED  <= (expect_ch == CH_R);
               end
            end else if (bitcnt != 5'd31) begin
               bitcnt <= bitcnt + 5'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ika2151_dac_receiver.sv
// Bench for ika2151_dac_receiver: arithmetic reference model checked every
// cycle against two instances (exponent-0 mute on and off), plus literal checks.
module tb_ika2151_dac_receiver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en_n = 1'b1;
   logic so = 1'b0;
   logic sh1 = 1'b1;
   logic sh2 = 1'b1;

   logic [15:0] l_m, r_m, l_n, r_n;
   logic lv_m, rv_m, err_m, lock_m, lv_n, rv_n, err_n, lock_n;

   always #5 clk = ~clk;

   ika2151_dac_receiver #(.ZERO_EXP_MUTE(1)) dut_m (
      .i_EMUCLK(clk), .i_RST(rst), .i_phi1_NCEN_n(en_n), .i_SO(so),
      .i_SH1(sh1), .i_SH2(sh2), .o_L(l_m), .o_R(r_m), .o_L_VALID(lv_m),
      .o_R_VALID(rv_m), .o_FRAME_ERR(err_m), .o_LOCKED(lock_m));

   ika2151_dac_receiver #(.ZERO_EXP_MUTE(0)) dut_n (
      .i_EMUCLK(clk), .i_RST(rst), .i_phi1_NCEN_n(en_n), .i_SO(so),
      .i_SH1(sh1), .i_SH2(sh2), .o_L(l_n), .o_R(r_n), .o_L_VALID(lv_n),
      .o_R_VALID(rv_n), .o_FRAME_ERR(err_n), .o_LOCKED(lock_n));

   int checks = 0;
   int errors = 0;
   bit armed = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {LAST_NONE, LAST_L, LAST_R} last_t;
   localparam int CH_L = 0, CH_R = 1, CH_BOTH = 2;

   bit    hist[$];          // serial bits seen on enable cycles since reset
   int    since;            // enables since the last strobe edge (edge counts as 1)
   bit    prev1, prev2;
   last_t last;
   logic [15:0] e_l1, e_r1, e_l0, e_r0;
   bit    e_lv, e_rv, e_err, e_lock;

   function automatic logic [15:0] dec(input logic [15:0] w, input bit mute);
      int m = int'(w[12:3]);
      int e = int'(w[15:13]);
      int v;
      if (e == 0 && mute) return 16'h0000;
      if (e == 0) e = 1;
      v = (m - 512) * (1 << (e - 1));
      return v[15:0];
   endfunction

   task automatic model_step(input bit r, input bit en, input bit s, input bit s1, input bit s2);
      bit f1, f2;
      logic [15:0] w;
      bit in_order;
      e_lv = 0; e_rv = 0; e_err = 0;
      if (r) begin
         hist.delete();
         since = 0; prev1 = 0; prev2 = 0; last = LAST_NONE;
         e_l1 = 0; e_r1 = 0; e_l0 = 0; e_r0 = 0; e_lock = 0;
         return;
      end
      if (en) return;
      f1 = prev1 && !s1;
      f2 = prev2 && !s2;
      for (int k = 0; k < 16; k++) begin
         int idx = hist.size() - 16 + k;
         w[k] = (idx >= 0) ? hist[idx] : 1'b0;
      end
      if (f1 || f2) begin
         if ((f1 && f2) || since != 16) begin
            e_err = 1; e_lock = 0;
         end else begin
            in_order = f1 ? (last != LAST_L) : (last == LAST_L);
            if (!in_order) e_lock = 0;
            else if (f2) e_lock = 1;
            if (f1) begin
               e_l1 = dec(w, 1); e_l0 = dec(w, 0); e_lv = 1; last = LAST_L;
            end else begin
               e_r1 = dec(w, 1); e_r0 = dec(w, 0); e_rv = 1; last = LAST_R;
            end
         end
         since = 1;
      end else begin
         since++;
      end
      hist.push_back(s);
      if (hist.size() > 16) void'(hist.pop_front());
      prev1 = s1; prev2 = s2;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (armed) begin
         check("o_L", l_m, e_l1);
         check("o_R", r_m, e_r1);
         check("o_L nomute", l_n, e_l0);
         check("o_R nomute", r_n, e_r0);
         check("o_L_VALID", 16'(lv_m), 16'(e_lv));
         check("o_R_VALID", 16'(rv_m), 16'(e_rv));
         check("o_FRAME_ERR", 16'(err_m), 16'(e_err));
         check("o_LOCKED", 16'(lock_m), 16'(e_lock));
         check("o_L_VALID nomute", 16'(lv_n), 16'(e_lv));
         check("o_R_VALID nomute", 16'(rv_n), 16'(e_rv));
         check("o_FRAME_ERR nomute", 16'(err_n), 16'(e_err));
         check("o_LOCKED nomute", 16'(lock_n), 16'(e_lock));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit r, input bit en, input bit s, input bit s1, input bit s2);
      rst = r; en_n = en; so = s; sh1 = s1; sh2 = s2;
      @(posedge clk);
      model_step(r, en, s, s1, s2);
      #1;
   endtask

   // One enable cycle followed by 0..2 disabled cycles carrying junk.
   task automatic enable(input bit s, input bit s1, input bit s2);
      int idle;
      cyc(0, 0, s, s1, s2);
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++)
         cyc(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   // n-1 plain enables carrying the top bits of the word, then the strobe edge.
   task automatic deliver(input int ch, input logic [15:0] word, input int n);
      for (int j = 0; j < n - 1; j++) begin
         int idx = 17 - n + j;
         enable((idx >= 0 && idx < 16) ? word[idx] : 1'b0, 1'b1, 1'b1);
      end
      cyc(0, 0, 1'b0, ch == CH_R, ch == CH_L);
   endtask

   function automatic logic [15:0] wd(input logic [9:0] m, input logic [2:0] e);
      return {e, m, 3'b110};
   endfunction

   initial begin
      cyc(1, 1, 0, 1, 1);
      cyc(1, 0, 1, 1, 1);
      armed = 1'b1;
      check("reset o_L", l_m, 16'h0000);
      check("reset o_LOCKED", 16'(lock_m), 16'h0000);

      // first word after reset: 16 enables then the SH1 edge
      deliver(CH_L, wd(10'h3FF, 3'd7), 17);
      check("first L valid", 16'(lv_m), 16'h0001);
      check("first L no err", 16'(err_m), 16'h0000);
      check("first L value", l_m, 16'h7FC0);
      deliver(CH_R, wd(10'h000, 3'd7), 16);
      check("first R value", r_m, 16'h8000);
      check("lock after L,R", 16'(lock_m), 16'h0001);

      // decode sweep
      deliver(CH_L, wd(10'h201, 3'd1), 16);
      check("m201 e1", l_m, 16'h0001);
      deliver(CH_R, wd(10'h200, 3'd5), 16);
      check("m200 e5", r_m, 16'h0000);
      deliver(CH_L, wd(10'h1FF, 3'd2), 16);
      check("m1FF e2", l_m, 16'hFFFE);
      deliver(CH_R, wd(10'h2AA, 3'd0), 16);
      check("e0 muted", r_m, 16'h0000);
      check("e0 unmuted", r_n, 16'h00AA);
      check("still locked", 16'(lock_m), 16'h0001);

      // short frame
      deliver(CH_L, wd(10'h123, 3'd3), 12);
      check("short err", 16'(err_m), 16'h0001);
      check("short L held", l_m, 16'hFFFE);
      check("short unlock", 16'(lock_m), 16'h0000);
      deliver(CH_L, wd(10'h100, 3'd3), 16);
      check("recover L", l_m, 16'hFC00);
      deliver(CH_R, wd(10'h300, 3'd4), 16);
      check("recover R", r_m, 16'h0800);
      check("relock", 16'(lock_m), 16'h0001);

      // simultaneous strobes
      deliver(CH_BOTH, wd(10'h055, 3'd6), 16);
      check("both err", 16'(err_m), 16'h0001);
      check("both L held", l_m, 16'hFC00);
      check("both R held", r_m, 16'h0800);

      // out-of-order R, then a proper pair
      deliver(CH_R, wd(10'h3FF, 3'd1), 16);
      check("ooo R value", r_m, 16'h01FF);
      check("ooo no lock", 16'(lock_m), 16'h0000);
      deliver(CH_L, wd(10'h000, 3'd1), 16);
      check("pair L", l_m, 16'hFE00);
      deliver(CH_R, wd(10'h201, 3'd7), 16);
      check("pair R", r_m, 16'h0040);
      check("pair lock", 16'(lock_m), 16'h0001);

      // reset mid-word while locked
      for (int i = 0; i < 5; i++) enable(1'b1, 1'b1, 1'b1);
      cyc(1, 0, 1, 1, 1);
      check("midreset o_L", l_m, 16'h0000);
      check("midreset o_R", r_m, 16'h0000);
      check("midreset lock", 16'(lock_m), 16'h0000);
      deliver(CH_L, wd(10'h3FF, 3'd7), 10);
      check("post-reset err", 16'(err_m), 16'h0001);
      deliver(CH_L, wd(10'h3FF, 3'd7), 16);
      check("post-reset L", l_m, 16'h7FC0);
      deliver(CH_R, wd(10'h000, 3'd7), 16);
      check("post-reset R", r_m, 16'h8000);
      check("post-reset lock", 16'(lock_m), 16'h0001);

      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 1);
      armed = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
